interrupt_sequencer: RTL and testbench

- Drives the program counter's interrupt interface: vector loads on entry, return-address selects on return.
- Synchronises and edge-detects two external interrupt requests, INT0 (highest priority) and INT1, and arbitrates them against the RETI instruction.
- Tracks in-service levels, with nesting limited to INT0 preempting INT1.
- Sits between the instruction sequencer (FETCH, RETI, INT_EN) and the program counter (PC_NEXTX, PC_LD_INT0X, PC_LD_INT1X).

---
 rtl/interrupt_sequencer.sv | 121 ++++++++++++
 tb/tb_interrupt_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: synchronises INT0/INT1 requests, arbitrates them
// against RETI and steers the program counter's interrupt interface.
module interrupt_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FETCH,
    input  logic       INT_EN,
    input  logic       RETI,
    input  logic       INT0_REQ,
    input  logic       INT1_REQ,
    output logic [2:0] PC_NEXTX,
    output logic       PC_LD_INT0X,
    output logic       PC_LD_INT1X,
    output logic       INT0_ACK,
    output logic       INT1_ACK,
    output logic [1:0] IN_SERVICE,
    output logic       RETI_ERR
);

    localparam logic [2:0] NX_NEXT  = 3'd0;
    localparam logic [2:0] NX_INTV0 = 3'd1;
    localparam logic [2:0] NX_INTV1 = 3'd2;
    localparam logic [2:0] NX_INTR0 = 3'd3;
    localparam logic [2:0] NX_INTR1 = 3'd4;

    // Encoding doubles as the IN_SERVICE value.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        S0   = 2'b01,
        S1   = 2'b10,
        S01  = 2'b11
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync0_q, sync1_q;
    logic                   prev0_q, prev1_q;
    logic                   pend0_q, pend0_d;
    logic                   pend1_q, pend1_d;
    logic                   err_q, err_d;
    logic                   edge0, edge1;
    logic                   clr0, clr1;

    assign edge0 = sync0_q[SYNC_STAGES-1] & ~prev0_q;
    assign edge1 = sync1_q[SYNC_STAGES-1] & ~prev1_q;

    // A fresh edge wins over a same-cycle clear so it is not lost.
    assign pend0_d = (pend0_q & ~clr0) | edge0;
    assign pend1_d = (pend1_q & ~clr1) | edge1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync0_q <= '0;
            sync1_q <= '0;
            prev0_q <= 1'b0;
            prev1_q <= 1'b0;
            pend0_q <= 1'b0;
            pend1_q <= 1'b0;
            err_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            sync0_q <= {sync0_q[SYNC_STAGES-2:0], INT0_REQ};
            sync1_q <= {sync1_q[SYNC_STAGES-2:0], INT1_REQ};
            prev0_q <= sync0_q[SYNC_STAGES-1];
            prev1_q <= sync1_q[SYNC_STAGES-1];
            pend0_q <= pend0_d;
            pend1_q <= pend1_d;
            err_q   <= err_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        PC_NEXTX    = NX_NEXT;
        PC_LD_INT0X = 1'b0;
        PC_LD_INT1X = 1'b0;
        INT0_ACK    = 1'b0;
        INT1_ACK    = 1'b0;
        clr0        = 1'b0;
        clr1        = 1'b0;
        if (FETCH) begin
            if (RETI) begin
                unique case (state_q)
                    S0: begin
                        state_d  = IDLE;
                        PC_NEXTX = NX_INTR0;
                    end
                    S01: begin
                        state_d  = S1;
                        PC_NEXTX = NX_INTR0;
                    end
                    S1: begin
                        state_d  = IDLE;
                        PC_NEXTX = NX_INTR1;
                    end
                    default: err_d = 1'b1;
                endcase
            end else if (INT_EN && pend0_q &&
                         (state_q == IDLE || state_q == S1)) begin
                PC_NEXTX    = NX_INTV0;
                PC_LD_INT0X = 1'b1;
                INT0_ACK    = 1'b1;
                clr0        = 1'b1;
                state_d     = (state_q == S1) ? S01 : S0;
            end else if (INT_EN && pend1_q && state_q == IDLE) begin
                PC_NEXTX    = NX_INTV1;
                PC_LD_INT1X = 1'b1;
                INT1_ACK    = 1'b1;
                clr1        = 1'b1;
                state_d     = S1;
            end
        end
    end

    assign IN_SERVICE = state_q;
    assign RETI_ERR   = err_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: scoreboarded FETCH decisions plus a
// small program-counter model fed by the sequencer's controls.
module tb_interrupt_sequencer;

    localparam logic [6:0] C_NONE = 7'b000_0000;
    localparam logic [6:0] C_E0   = 7'b001_1010;
    localparam logic [6:0] C_E1   = 7'b010_0101;
    localparam logic [6:0] C_R0   = 7'b011_0000;
    localparam logic [6:0] C_R1   = 7'b100_0000;

    typedef struct {
        string      tag;
        logic [6:0] ctl;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       FETCH = 1'b0;
    logic       INT_EN = 1'b0;
    logic       RETI = 1'b0;
    logic       INT0_REQ = 1'b0;
    logic       INT1_REQ = 1'b0;
    logic [2:0] PC_NEXTX;
    logic       PC_LD_INT0X, PC_LD_INT1X;
    logic       INT0_ACK, INT1_ACK;
    logic [1:0] IN_SERVICE;
    logic       RETI_ERR;

    int n_chk = 0;
    int n_err = 0;
    exp_t exp_q[$];

    logic [15:0] pc = 16'h00F8;
    logic [15:0] intr0 = 16'h0;
    logic [15:0] intr1 = 16'h0;
    logic [15:0] saved;

    interrupt_sequencer #(.SYNC_STAGES(2)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .FETCH(FETCH),
        .INT_EN(INT_EN),
        .RETI(RETI),
        .INT0_REQ(INT0_REQ),
        .INT1_REQ(INT1_REQ),
        .PC_NEXTX(PC_NEXTX),
        .PC_LD_INT0X(PC_LD_INT0X),
        .PC_LD_INT1X(PC_LD_INT1X),
        .INT0_ACK(INT0_ACK),
        .INT1_ACK(INT1_ACK),
        .IN_SERVICE(IN_SERVICE),
        .RETI_ERR(RETI_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ctl_now();
        return {PC_NEXTX, PC_LD_INT0X, PC_LD_INT1X, INT0_ACK, INT1_ACK};
    endfunction

    // Monitor: compares each FETCH decision and advances the PC model.
    always @(negedge CLK) begin
        logic [6:0] obs;
        logic [15:0] nxt;
        exp_t e;
        #2;
        obs = ctl_now();
        if (FETCH) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                chk(e.tag, {25'd0, obs}, {25'd0, e.ctl});
            end
            case (PC_NEXTX)
                3'd1: nxt = 16'h0004;
                3'd2: nxt = 16'h0008;
                3'd3: nxt = intr0;
                3'd4: nxt = intr1;
                default: nxt = pc + 16'd2;
            endcase
            if (PC_LD_INT0X) intr0 = pc + 16'd2;
            if (PC_LD_INT1X) intr1 = pc + 16'd2;
            pc = nxt;
        end else if (!RESET) begin
            chk("idle_ctl", {25'd0, obs}, 0);
        end
    end

    task automatic idle(int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic fetch(string tag, bit reti, logic [6:0] ctl,
                         logic [1:0] svc);
        exp_q.push_back('{tag: tag, ctl: ctl});
        FETCH = 1'b1;
        RETI  = reti;
        @(negedge CLK);
        FETCH = 1'b0;
        RETI  = 1'b0;
        chk({tag, "_svc"}, {30'd0, IN_SERVICE}, {30'd0, svc});
    endtask

    task automatic pulse(bit r0, bit r1);
        INT0_REQ = r0;
        INT1_REQ = r1;
        idle(2);
        INT0_REQ = 1'b0;
        INT1_REQ = 1'b0;
        idle(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle(3);
        chk("rst_ctl", {25'd0, ctl_now()}, 0);
        chk("rst_svc", {30'd0, IN_SERVICE}, 0);
        chk("rst_err", {31'd0, RETI_ERR}, 0);
        RESET = 1'b0;
        idle(2);

        for (int i = 0; i < 4; i++) fetch("quiet", 0, C_NONE, 2'b00);
        chk("pc_start", {16'd0, pc}, 32'h0100);

        INT_EN = 1'b1;
        pulse(0, 1);
        fetch("int1_entry", 0, C_E1, 2'b10);
        chk("pc_vec1", {16'd0, pc}, 32'h0008);
        chk("intr1", {16'd0, intr1}, 32'h0102);
        fetch("s1_body", 0, C_NONE, 2'b10);
        fetch("int1_reti", 1, C_R1, 2'b00);
        chk("pc_ret1", {16'd0, pc}, 32'h0102);

        pulse(0, 1);
        fetch("nest_e1", 0, C_E1, 2'b10);
        saved = pc;
        pulse(1, 0);
        fetch("nest_e0", 0, C_E0, 2'b11);
        chk("intr0", {16'd0, intr0}, {16'd0, saved + 16'd2});
        fetch("nest_r0", 1, C_R0, 2'b10);
        chk("pc_ret0", {16'd0, pc}, {16'd0, saved + 16'd2});
        fetch("nest_r1", 1, C_R1, 2'b00);

        pulse(1, 0);
        fetch("blk_e0", 0, C_E0, 2'b01);
        pulse(0, 1);
        fetch("blk_hold", 0, C_NONE, 2'b01);
        fetch("blk_r0", 1, C_R0, 2'b00);
        fetch("blk_e1", 0, C_E1, 2'b10);
        fetch("blk_r1", 1, C_R1, 2'b00);

        pulse(1, 1);
        fetch("sim_e0", 0, C_E0, 2'b01);
        fetch("sim_r0", 1, C_R0, 2'b00);
        fetch("sim_e1", 0, C_E1, 2'b10);
        fetch("sim_r1", 1, C_R1, 2'b00);

        INT_EN = 1'b0;
        pulse(1, 0);
        for (int i = 0; i < 10; i++) fetch("en_off", 0, C_NONE, 2'b00);
        INT_EN = 1'b1;
        fetch("en_on_e0", 0, C_E0, 2'b01);
        fetch("en_on_r0", 1, C_R0, 2'b00);
        chk("err_clear", {31'd0, RETI_ERR}, 0);

        fetch("reti_idle", 1, C_NONE, 2'b00);
        chk("err_set", {31'd0, RETI_ERR}, 1);
        fetch("after_err", 0, C_NONE, 2'b00);
        idle(3);
        chk("err_sticky", {31'd0, RETI_ERR}, 1);

        RESET = 1'b1;
        idle(1);
        chk("rst2_err", {31'd0, RETI_ERR}, 0);
        chk("rst2_svc", {30'd0, IN_SERVICE}, 0);
        RESET = 1'b0;
        idle(2);
        chk("sb_drain", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
